// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 NRZ stream receiver: pulse-width bit decode, 24-bit word assembly, latch-gap framing.
module ws2812_rx #(
    parameter int CLK_MHZ  = 12,
    parameter int NUM_LEDS = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     din,
    output logic [23:0]                              rgb_colour,
    output logic                                     rgb_valid,
    output logic [(NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1)-1:0] led_index,
    output logic                                     frame_done,
    output logic                                     frame_error
);
    localparam int T_GLITCH = CLK_MHZ * 100 / 1000;
    localparam int T_BIT1   = CLK_MHZ * 600 / 1000;
    localparam int T_LATCH  = CLK_MHZ * 50;
    localparam int CW       = $clog2(T_LATCH + 1);
    localparam int IW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    // hi_cnt reads one less than the pulse width at the falling edge, because
    // the rising-edge cycle only clears it; the bit threshold compensates.
    localparam logic [CW-1:0] GLITCH_C = CW'(T_GLITCH);
    localparam logic [CW-1:0] BIT1_C   = CW'(T_BIT1 - 1);
    localparam logic [CW-1:0] LATCH_C  = CW'(T_LATCH - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic            din_prev_q;
    logic [CW-1:0]   hi_cnt_q;
    logic [CW-1:0]   lo_cnt_q;
    logic            from_low_q;
    logic [23:0]     shreg_q;
    logic [4:0]      bit_cnt_q;
    logic [IW-1:0]   next_idx_q;
    logic            idx_full_q;
    logic            overrun_q;
    logic [23:0]     rgb_colour_q;
    logic            rgb_valid_q;
    logic [IW-1:0]   led_index_q;
    logic            frame_done_q;
    logic            frame_error_q;

    logic din_s, rise_d, fall_d, bit_d;

    always_comb begin
        din_s  = sync_q[1];
        rise_d = din_s & ~din_prev_q;
        fall_d = ~din_s & din_prev_q;
        bit_d  = (hi_cnt_q >= BIT1_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sync_q        <= 2'b00;
            din_prev_q    <= 1'b0;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            from_low_q    <= 1'b0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            next_idx_q    <= '0;
            idx_full_q    <= 1'b0;
            overrun_q     <= 1'b0;
            rgb_colour_q  <= '0;
            rgb_valid_q   <= 1'b0;
            led_index_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], din};
            din_prev_q    <= din_s;
            rgb_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise_d) begin
                        hi_cnt_q   <= '0;
                        from_low_q <= 1'b0;
                        state_q    <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall_d) begin
                        if (hi_cnt_q < GLITCH_C) begin
                            state_q <= from_low_q ? LOW : IDLE;
                        end else begin
                            shreg_q  <= {shreg_q[22:0], bit_d};
                            lo_cnt_q <= '0;
                            state_q  <= LOW;
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q    <= '0;
                                rgb_colour_q <= {shreg_q[22:0], bit_d};
                                rgb_valid_q  <= 1'b1;
                                led_index_q  <= next_idx_q;
                                if (next_idx_q == LAST_IDX) begin
                                    if (idx_full_q) overrun_q <= 1'b1;
                                    idx_full_q <= 1'b1;
                                end else begin
                                    next_idx_q <= next_idx_q + 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end else if (hi_cnt_q != {CW{1'b1}}) begin
                        hi_cnt_q <= hi_cnt_q + 1'b1;
                    end
                end
                LOW: begin
                    if (rise_d) begin
                        hi_cnt_q   <= '0;
                        from_low_q <= 1'b1;
                        state_q    <= HIGH;
                    end else if (lo_cnt_q == LATCH_C) begin
                        frame_done_q  <= 1'b1;
                        frame_error_q <= (bit_cnt_q != 5'd0) || overrun_q;
                        bit_cnt_q     <= '0;
                        shreg_q       <= '0;
                        next_idx_q    <= '0;
                        led_index_q   <= '0;
                        idx_full_q    <= 1'b0;
                        overrun_q     <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        lo_cnt_q <= lo_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rgb_colour  = rgb_colour_q;
    assign rgb_valid   = rgb_valid_q;
    assign led_index   = led_index_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - scoreboard bench for ws2812_rx: directed words, boundary pulses, errors, reset.
module tb_ws2812_rx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic [23:0] rgb_colour;
    logic        rgb_valid;
    logic [1:0]  led_index;
    logic        frame_done;
    logic        frame_error;

    int checks = 0;
    int failures = 0;
    int words_seen = 0;
    int frames_seen = 0;
    int words_exp = 0;
    int frames_exp = 0;

    logic [25:0] exp_words[$];
    logic        exp_frames[$];

    ws2812_rx #(.CLK_MHZ(12), .NUM_LEDS(4)) dut (
        .clk(clk), .reset(reset), .din(din),
        .rgb_colour(rgb_colour), .rgb_valid(rgb_valid), .led_index(led_index),
        .frame_done(frame_done), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a word or frame event.
    always @(negedge clk) begin
        if (rgb_valid) begin
            words_seen++;
            if (exp_words.size() == 0) begin
                chk("unexpected_word", {8'h0, rgb_colour}, 32'hFFFF_FFFF);
            end else begin
                logic [25:0] e;
                e = exp_words.pop_front();
                chk("word_colour", {8'h0, rgb_colour}, {8'h0, e[25:2]});
                chk("word_index", {30'h0, led_index}, {30'h0, e[1:0]});
            end
        end
        if (frame_done) begin
            frames_seen++;
            if (exp_frames.size() == 0) begin
                chk("unexpected_frame", 32'h1, 32'h0);
            end else begin
                logic ef;
                ef = exp_frames.pop_front();
                chk("frame_error", {31'h0, frame_error}, {31'h0, ef});
            end
        end else if (frame_error) begin
            chk("error_without_done", 32'h1, 32'h0);
        end
    end

    task automatic expect_word(input logic [23:0] w, input logic [1:0] idx);
        exp_words.push_back({w, idx});
        words_exp++;
    endtask

    task automatic expect_frame(input logic err);
        exp_frames.push_back(err);
        frames_exp++;
    endtask

    task automatic send_bit(input logic b, input int h1, input int h0, input bit glitch);
        din = 1'b1;
        repeat (b ? h1 : h0) @(negedge clk);
        din = 1'b0;
        if (glitch) begin
            repeat (2) @(negedge clk);
            din = 1'b1;
            @(negedge clk);
            din = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits, input int h1, input int h0, input bit glitch);
        for (int i = 23; i > 23 - nbits; i--) send_bit(w[i], h1, h0, glitch);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bits(w, 24, 9, 4, 1'b0);
    endtask

    task automatic idle_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_colour", {8'h0, rgb_colour}, 32'h0);
        chk("reset_valid", {31'h0, rgb_valid}, 32'h0);
        chk("reset_index", {30'h0, led_index}, 32'h0);
        chk("reset_done", {31'h0, frame_done}, 32'h0);
        chk("reset_error", {31'h0, frame_error}, 32'h0);
        idle_low(700);
        chk("no_latch_from_idle", frames_seen, 0);

        // 1: single word
        expect_word(24'hAACCDD, 2'd0);
        expect_frame(1'b0);
        send_word(24'hAACCDD);
        idle_low(700);
        chk("t1_colour_hold", {8'h0, rgb_colour}, 32'hAACCDD);

        // 2: four words fill the frame exactly
        expect_word(24'h000001, 2'd0);
        expect_word(24'hFFFFFF, 2'd1);
        expect_word(24'h800000, 2'd2);
        expect_word(24'h123456, 2'd3);
        expect_frame(1'b0);
        send_word(24'h000001);
        send_word(24'hFFFFFF);
        send_word(24'h800000);
        send_word(24'h123456);
        idle_low(700);
        chk("t2_index_cleared", {30'h0, led_index}, 32'h0);

        // 3: 7-cycle high is a 1, 6-cycle high is a 0, 1-cycle glitches in every gap
        expect_word(24'h5A5A5A, 2'd0);
        expect_frame(1'b0);
        send_bits(24'h5A5A5A, 24, 7, 6, 1'b1);
        idle_low(700);

        // 4: partial word then a good word
        expect_frame(1'b1);
        send_bits(24'hFFC000, 10, 9, 4, 1'b0);
        idle_low(700);
        chk("t4_no_word", words_seen, words_exp);
        expect_word(24'h0F0F0F, 2'd0);
        expect_frame(1'b0);
        send_word(24'h0F0F0F);
        idle_low(700);

        // 5: overrun on a fifth word
        expect_word(24'h111111, 2'd0);
        expect_word(24'h222222, 2'd1);
        expect_word(24'h333333, 2'd2);
        expect_word(24'h444444, 2'd3);
        expect_word(24'h555555, 2'd3);
        expect_frame(1'b1);
        send_word(24'h111111);
        send_word(24'h222222);
        send_word(24'h333333);
        send_word(24'h444444);
        send_word(24'h555555);
        idle_low(700);

        // 6: reset mid-word, then 599-cycle gap that must not latch
        send_bits(24'hFFF000, 12, 9, 4, 1'b0);
        do_reset();
        chk("t6_reset_colour", {8'h0, rgb_colour}, 32'h0);
        chk("t6_reset_index", {30'h0, led_index}, 32'h0);
        expect_word(24'hAACCDD, 2'd0);
        send_word(24'hAACCDD);
        idle_low(593);
        chk("t6_no_early_latch", frames_seen, frames_exp);
        expect_word(24'h000001, 2'd1);
        expect_frame(1'b0);
        send_word(24'h000001);
        idle_low(700);

        chk("total_words", words_seen, words_exp);
        chk("total_frames", frames_seen, frames_exp);
        chk("words_drained", exp_words.size(), 0);
        chk("frames_drained", exp_frames.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
